// File: rtl/corr_pkg.sv
// Shared types and width helpers for the correlator control sequencer.
// The flag bundle order matches what the signal-delay stage unpacks.
package corr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   // A counter over n values still needs one bit when n is 1.
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int tbits(input int trate);
      return cnt_bits(trate);
   endfunction

   function automatic int lbits(input int loop0);
      return cnt_bits(loop0);
   endfunction

   // Delay-stage bundle is {addr, last, emit, next, first, valid}; addr is
   // parameter-sized, so it is concatenated ahead of this struct by the user.
   typedef struct packed {
      logic last;
      logic emit;
      logic next;
      logic first;
      logic valid;
   } flags_t;

   localparam int FLAG_W = $bits(flags_t);

endpackage

// File: rtl/loop_counter.sv
// Modulo-MOD counter that advances on inc_i; wrap_o flags the increment that
// returns it to zero, so instances chain by feeding wrap_o into inc_i.
module loop_counter #(
   parameter int MOD = 4,
   parameter int W   = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   logic [W-1:0] count_reg;
   logic [W-1:0] count_next;
   logic         at_max;

   assign at_max  = (count_reg == W'(MOD - 1));
   assign wrap_o  = inc_i && at_max;
   assign count_o = count_reg;

   always_comb begin
      count_next = count_reg;
      if (inc_i) begin
         count_next = at_max ? '0 : count_reg + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/corr_sequencer.sv
// Control-stream generator for the time-multiplexed correlator chains: replays
// each sample block once per timeslice and accumulates LOOP1 blocks per window.
module corr_sequencer
   import corr_pkg::*;
#(
   parameter int TRATE = 30,
   parameter int LOOP0 = 3,
   parameter int LOOP1 = 4,
   parameter int FBITS = 16,
   parameter int TBITS = tbits(TRATE),
   parameter int LBITS = lbits(LOOP0)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable_i,
   input  logic             buf_ready_i,
   output logic [LBITS-1:0] buf_addr_o,
   output logic             buf_done_o,
   output logic             valid_o,
   output logic             first_o,
   output logic             next_o,
   output logic             emit_o,
   output logic             last_o,
   output logic [TBITS-1:0] addr_o,
   output logic             busy_o,
   output logic [FBITS-1:0] windows_o
);

   localparam int CBITS = cnt_bits(LOOP1);

   state_t state_reg;
   state_t state_next;

   logic             run;
   logic [LBITS-1:0] cnt0;
   logic [TBITS-1:0] addr;
   logic [CBITS-1:0] cnt1;
   logic             cnt0_wrap;
   logic             addr_wrap;
   logic             cnt1_wrap;

   flags_t           flags_reg;
   flags_t           flags_next;
   logic             done_reg;
   logic             done_next;
   logic             busy_reg;
   logic             busy_next;
   logic [TBITS-1:0] taddr_reg;
   logic [TBITS-1:0] taddr_next;
   logic [LBITS-1:0] baddr_reg;
   logic [LBITS-1:0] baddr_next;
   logic [FBITS-1:0] windows_reg;
   logic [FBITS-1:0] windows_next;

   assign run = (state_reg == RUN);

   // Innermost to outermost: sample in block, timeslice, accumulated block.
   loop_counter #(.MOD(LOOP0), .W(LBITS)) u_cnt0 (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (run),
      .count_o (cnt0),
      .wrap_o  (cnt0_wrap)
   );

   loop_counter #(.MOD(TRATE), .W(TBITS)) u_addr (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (cnt0_wrap),
      .count_o (addr),
      .wrap_o  (addr_wrap)
   );

   loop_counter #(.MOD(LOOP1), .W(CBITS)) u_cnt1 (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (addr_wrap),
      .count_o (cnt1),
      .wrap_o  (cnt1_wrap)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      flags_next   = '0;
      done_next    = 1'b0;
      busy_next    = (state_reg != IDLE);
      taddr_next   = taddr_reg;
      baddr_next   = baddr_reg;
      windows_next = windows_reg;

      case (state_reg)
         IDLE: begin
            if (enable_i) begin
               state_next = WAIT;
            end
         end

         WAIT: begin
            if (buf_ready_i) begin
               state_next = RUN;
            end
         end

         RUN: begin
            flags_next.valid = 1'b1;
            flags_next.first = (cnt1 == '0) && (cnt0 == '0);
            flags_next.next  = (cnt0 == LBITS'(LOOP0 - 1));
            flags_next.emit  = flags_next.next && (cnt1 == CBITS'(LOOP1 - 1));
            flags_next.last  = flags_next.emit && (addr == TBITS'(TRATE - 1));
            taddr_next       = addr;
            baddr_next       = cnt0;
            done_next        = addr_wrap;

            // enable_i only matters here at the window boundary, so a
            // mid-window drop still lets the window finish.
            if (addr_wrap) begin
               if (cnt1_wrap) begin
                  windows_next = windows_reg + 1'b1;
                  state_next   = enable_i ? WAIT : IDLE;
               end else begin
                  state_next = WAIT;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         flags_reg   <= '0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         taddr_reg   <= '0;
         baddr_reg   <= '0;
         windows_reg <= '0;
      end else begin
         flags_reg   <= flags_next;
         done_reg    <= done_next;
         busy_reg    <= busy_next;
         taddr_reg   <= taddr_next;
         baddr_reg   <= baddr_next;
         windows_reg <= windows_next;
      end
   end

   assign valid_o    = flags_reg.valid;
   assign first_o    = flags_reg.first;
   assign next_o     = flags_reg.next;
   assign emit_o     = flags_reg.emit;
   assign last_o     = flags_reg.last;
   assign buf_done_o = done_reg;
   assign busy_o     = busy_reg;
   assign addr_o     = taddr_reg;
   assign buf_addr_o = baddr_reg;
   assign windows_o  = windows_reg;

endmodule

// File: tb/tb_corr_sequencer.sv
// Directed bench: instance A (TRATE=4, LOOP0=3, LOOP1=2) for window shape,
// stalls, enable drop and mid-run reset; instance B for LOOP0=LOOP1=1 and FBITS=2.
module tb_corr_sequencer;

   logic clock;
   logic reset;

   logic       a_en, a_rdy;
   logic [1:0] a_baddr;
   logic       a_done, a_valid, a_first, a_next, a_emit, a_last, a_busy;
   logic [1:0] a_addr;
   logic [15:0] a_windows;

   logic       b_en, b_rdy;
   logic [0:0] b_baddr;
   logic       b_done, b_valid, b_first, b_next, b_emit, b_last, b_busy;
   logic [0:0] b_addr;
   logic [1:0] b_windows;

   int passed = 0;
   int fails  = 0;
   int total  = 0;

   // Per-window observations of instance A, indexed by valid-cycle number.
   logic [31:0] m_first, m_next, m_emit, m_last, m_done;
   int n_valid, gap, max_gap, gap_flags, pos_err, win_at_last;

   corr_sequencer #(.TRATE(4), .LOOP0(3), .LOOP1(2), .FBITS(16)) dut_a (
      .clock       (clock),
      .reset       (reset),
      .enable_i    (a_en),
      .buf_ready_i (a_rdy),
      .buf_addr_o  (a_baddr),
      .buf_done_o  (a_done),
      .valid_o     (a_valid),
      .first_o     (a_first),
      .next_o      (a_next),
      .emit_o      (a_emit),
      .last_o      (a_last),
      .addr_o      (a_addr),
      .busy_o      (a_busy),
      .windows_o   (a_windows)
   );

   corr_sequencer #(.TRATE(2), .LOOP0(1), .LOOP1(1), .FBITS(2)) dut_b (
      .clock       (clock),
      .reset       (reset),
      .enable_i    (b_en),
      .buf_ready_i (b_rdy),
      .buf_addr_o  (b_baddr),
      .buf_done_o  (b_done),
      .valid_o     (b_valid),
      .first_o     (b_first),
      .next_o      (b_next),
      .emit_o      (b_emit),
      .last_o      (b_last),
      .addr_o      (b_addr),
      .busy_o      (b_busy),
      .windows_o   (b_windows)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
      $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_en = 1'b0; a_rdy = 1'b0;
      b_en = 1'b0; b_rdy = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Observe instance A until stop_n valid cycles have been seen. gap_hold
   // stalls buf_ready after the first block; drop_at clears enable at that
   // valid-cycle index.
   task automatic collect_a(input int gap_hold, input int drop_at, input int stop_n);
      int hold;
      int vi;
      m_first = '0; m_next = '0; m_emit = '0; m_last = '0; m_done = '0;
      n_valid = 0; gap = 0; max_gap = 0; gap_flags = 0; pos_err = 0;
      win_at_last = -1; hold = 0;
      for (int cyc = 0; cyc < 400 && n_valid < stop_n; cyc++) begin
         @(negedge clock);
         if (a_valid) begin
            vi = n_valid;
            if (a_first) m_first |= 32'(1) << vi;
            if (a_next)  m_next  |= 32'(1) << vi;
            if (a_emit)  m_emit  |= 32'(1) << vi;
            if (a_last)  m_last  |= 32'(1) << vi;
            if (a_done)  m_done  |= 32'(1) << vi;
            if (a_last)  win_at_last = int'(a_windows);
            if (int'(a_addr) != (vi % 12) / 3 || int'(a_baddr) != vi % 3) pos_err++;
            if (gap > max_gap) max_gap = gap;
            gap = 0;
            n_valid++;
            if (vi == drop_at) a_en = 1'b0;
            if (vi == 11 && gap_hold > 0) hold = gap_hold;
         end else begin
            if (n_valid > 0) gap++;
            if (a_first | a_next | a_emit | a_last | a_done) gap_flags++;
         end
         if (hold > 0) begin
            a_rdy = 1'b0;
            hold--;
         end else begin
            a_rdy = 1'b1;
         end
      end
   endtask

   int nb;
   int bad_b;
   int idle_valid;
   int wobs[5];
   int wexp[5] = '{1, 2, 3, 0, 1};

   initial begin
      reset = 1'b1;
      a_en = 1'b0; a_rdy = 1'b0;
      b_en = 1'b0; b_rdy = 1'b0;

      // Reset state
      do_reset();
      chk("reset_flags", 64'({a_valid, a_first, a_next, a_emit, a_last, a_done, a_busy}), 64'd0);
      chk("reset_addr", 64'(a_addr), 64'd0);
      chk("reset_buf_addr", 64'(a_baddr), 64'd0);
      chk("reset_windows", 64'(a_windows), 64'd0);

      // Scenario 1: free-running window
      a_en = 1'b1; a_rdy = 1'b1;
      collect_a(0, -1, 24);
      chk("s1_n_valid", 64'(n_valid), 64'd24);
      chk("s1_first", 64'(m_first), 64'h249);
      chk("s1_next", 64'(m_next), 64'h924924);
      chk("s1_emit", 64'(m_emit), 64'h924000);
      chk("s1_last", 64'(m_last), 64'h800000);
      chk("s1_done", 64'(m_done), 64'h800800);
      chk("s1_addr_seq_err", 64'(pos_err), 64'd0);
      chk("s1_max_gap", 64'(max_gap), 64'd1);
      chk("s1_gap_flags", 64'(gap_flags), 64'd0);
      chk("s1_windows", 64'(win_at_last), 64'd1);

      // Scenario 2: buffer stall after the first block
      do_reset();
      a_en = 1'b1; a_rdy = 1'b1;
      collect_a(5, -1, 24);
      chk("s2_n_valid", 64'(n_valid), 64'd24);
      chk("s2_first", 64'(m_first), 64'h249);
      chk("s2_emit", 64'(m_emit), 64'h924000);
      chk("s2_last", 64'(m_last), 64'h800000);
      chk("s2_done", 64'(m_done), 64'h800800);
      chk("s2_max_gap", 64'(max_gap), 64'd6);
      chk("s2_gap_flags", 64'(gap_flags), 64'd0);
      chk("s2_windows", 64'(win_at_last), 64'd1);

      // Scenario 3: enable dropped mid-window
      do_reset();
      a_en = 1'b1; a_rdy = 1'b1;
      collect_a(0, 5, 24);
      chk("s3_n_valid", 64'(n_valid), 64'd24);
      chk("s3_last", 64'(m_last), 64'h800000);
      chk("s3_windows", 64'(win_at_last), 64'd1);
      idle_valid = 0;
      repeat (20) begin
         @(negedge clock);
         if (a_valid) idle_valid++;
      end
      chk("s3_valid_after", 64'(idle_valid), 64'd0);
      chk("s3_busy_after", 64'(a_busy), 64'd0);
      chk("s3_windows_after", 64'(a_windows), 64'd1);

      // Scenario 4: reset at valid cycle 10, then restart
      do_reset();
      a_en = 1'b1; a_rdy = 1'b1;
      collect_a(0, -1, 11);
      chk("s4_pre_n_valid", 64'(n_valid), 64'd11);
      reset = 1'b1;
      @(negedge clock);
      chk("s4_rst_flags", 64'({a_valid, a_first, a_next, a_emit, a_last, a_done, a_busy}), 64'd0);
      chk("s4_rst_addr", 64'({a_addr, a_baddr}), 64'd0);
      chk("s4_rst_windows", 64'(a_windows), 64'd0);
      reset = 1'b0;
      collect_a(0, -1, 24);
      chk("s4_first", 64'(m_first), 64'h249);
      chk("s4_last", 64'(m_last), 64'h800000);
      chk("s4_windows", 64'(win_at_last), 64'd1);

      // Scenarios 5 and 6: LOOP0=LOOP1=1, TRATE=2, FBITS=2, five windows
      do_reset();
      b_en = 1'b1; b_rdy = 1'b1;
      nb = 0; bad_b = 0;
      for (int i = 0; i < 5; i++) wobs[i] = -1;
      for (int cyc = 0; cyc < 200 && nb < 10; cyc++) begin
         @(negedge clock);
         if (b_valid) begin
            if (!(b_first && b_next && b_emit)) bad_b++;
            if (int'(b_last) != nb % 2) bad_b++;
            if (int'(b_done) != nb % 2) bad_b++;
            if (int'(b_addr) != nb % 2) bad_b++;
            if (b_baddr != 1'b0) bad_b++;
            if (b_last) wobs[nb / 2] = int'(b_windows);
            nb++;
         end else if (b_first | b_next | b_emit | b_last | b_done) begin
            bad_b++;
         end
      end
      chk("s5_n_valid", 64'(nb), 64'd10);
      chk("s5_flag_err", 64'(bad_b), 64'd0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("s6_windows_%0d", i), 64'(wobs[i]), 64'(wexp[i]));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
